// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage pipeline: EX/MEM forwarding, load-use detection,
// per-register scoreboard for long-latency writers, and a saturating stall counter.
module hazard_scoreboard #(
  parameter int NREG   = 32,
  parameter int RA_W   = 5,
  parameter int LAT_W  = 4,
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              d_valid,
  input  logic [RA_W-1:0]   d_rs1,
  input  logic [RA_W-1:0]   d_rs2,
  input  logic              d_use_rs1,
  input  logic              d_use_rs2,
  input  logic [RA_W-1:0]   d_rd,
  input  logic              d_regwrite,
  input  logic [LAT_W-1:0]  d_lat,
  input  logic              d_var_lat,
  input  logic [RA_W-1:0]   e_rs1,
  input  logic [RA_W-1:0]   e_rs2,
  input  logic              e_use_rs2,
  input  logic [RA_W-1:0]   e_rd,
  input  logic              e_regwrite,
  input  logic              e_memread,
  input  logic [RA_W-1:0]   m_rd,
  input  logic              m_regwrite,
  input  logic              m_memwrite,
  input  logic [RA_W-1:0]   m_rs2,
  input  logic [RA_W-1:0]   w_rd,
  input  logic              w_regwrite,
  input  logic              mc_wb_valid,
  input  logic [RA_W-1:0]   mc_wb_rd,
  input  logic              flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              fwd_c,
  output logic              stall,
  output logic              bubble_e,
  output logic [NREG-1:0]   sb_busy,
  output logic [PERF_W-1:0] stall_cnt
);

  logic [NREG-1:0]  busy;
  logic [NREG-1:0]  is_var;
  logic [LAT_W-1:0] cnt [NREG];

  logic hit1, hit2, load_use, raw, waw, hazard, issue;

  always_comb begin
    fwd_a = 2'b00;
    if (m_regwrite && m_rd != '0 && m_rd == e_rs1)      fwd_a = 2'b01;
    else if (w_regwrite && w_rd != '0 && w_rd == e_rs1) fwd_a = 2'b10;

    fwd_b = 2'b00;
    if (e_use_rs2) begin
      if (m_regwrite && m_rd != '0 && m_rd == e_rs2)      fwd_b = 2'b01;
      else if (w_regwrite && w_rd != '0 && w_rd == e_rs2) fwd_b = 2'b10;
    end

    fwd_c = m_memwrite && w_regwrite && (w_rd != '0) && (w_rd == m_rs2);
  end

  always_comb begin
    hit1     = d_use_rs1 && (d_rs1 != '0);
    hit2     = d_use_rs2 && (d_rs2 != '0);
    load_use = e_memread && e_regwrite && (e_rd != '0) &&
               ((hit1 && e_rd == d_rs1) || (hit2 && e_rd == d_rs2));
    raw      = (hit1 && busy[d_rs1]) || (hit2 && busy[d_rs2]);
    waw      = d_regwrite && (d_rd != '0) && busy[d_rd];
    hazard   = d_valid && (load_use || raw || waw);
    stall    = hazard && !flush;
    bubble_e = stall;
    issue    = d_valid && !stall && !flush && d_regwrite && (d_rd != '0) &&
               ((d_lat != '0) || d_var_lat);
  end

  assign sb_busy = busy;

  // Per entry: retire first, then an issue to the same index overrides.
  // WAW stalling guarantees the two never collide on a busy entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= '0;
      is_var <= '0;
      for (int unsigned i = 0; i < NREG; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (busy[i] && !is_var[i]) begin
          if (cnt[i] == LAT_W'(1)) busy[i] <= 1'b0;
          cnt[i] <= cnt[i] - 1'b1;
        end
        if (busy[i] && is_var[i] && mc_wb_valid && mc_wb_rd == RA_W'(i)) begin
          busy[i]   <= 1'b0;
          is_var[i] <= 1'b0;
        end
        if (issue && d_rd == RA_W'(i)) begin
          busy[i]   <= 1'b1;
          is_var[i] <= d_var_lat;
          cnt[i]    <= d_lat;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       stall_cnt <= '0;
    else if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a ready-time reference model.
`timescale 1ns/1ps
module tb_hazard_scoreboard;
  localparam int NREG = 32, RA_W = 5, LAT_W = 4, PW = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic d_valid = 0, d_use_rs1 = 0, d_use_rs2 = 0, d_regwrite = 0, d_var_lat = 0;
  logic [RA_W-1:0] d_rs1 = 0, d_rs2 = 0, d_rd = 0;
  logic [LAT_W-1:0] d_lat = 0;
  logic [RA_W-1:0] e_rs1 = 0, e_rs2 = 0, e_rd = 0, m_rd = 0, m_rs2 = 0, w_rd = 0, mc_wb_rd = 0;
  logic e_use_rs2 = 0, e_regwrite = 0, e_memread = 0, m_regwrite = 0, m_memwrite = 0;
  logic w_regwrite = 0, mc_wb_valid = 0, flush = 0;
  logic [1:0] fwd_a, fwd_b;
  logic fwd_c, stall, bubble_e;
  logic [NREG-1:0] sb_busy;
  logic [PW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  hazard_scoreboard #(.NREG(NREG), .RA_W(RA_W), .LAT_W(LAT_W), .PERF_W(PW)) dut (
    .clk(clk), .rst_n(rst_n),
    .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2), .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2),
    .d_rd(d_rd), .d_regwrite(d_regwrite), .d_lat(d_lat), .d_var_lat(d_var_lat),
    .e_rs1(e_rs1), .e_rs2(e_rs2), .e_use_rs2(e_use_rs2), .e_rd(e_rd), .e_regwrite(e_regwrite),
    .e_memread(e_memread), .m_rd(m_rd), .m_regwrite(m_regwrite), .m_memwrite(m_memwrite),
    .m_rs2(m_rs2), .w_rd(w_rd), .w_regwrite(w_regwrite), .mc_wb_valid(mc_wb_valid),
    .mc_wb_rd(mc_wb_rd), .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_c(fwd_c),
    .stall(stall), .bubble_e(bubble_e), .sb_busy(sb_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: a fixed-latency register is busy while cyc < ready_at,
  // a variable-latency register while vpend is set.
  longint cyc = 0;
  longint ready_at [NREG];
  bit     vpend [NREG];
  int     m_scnt = 0;

  initial for (int r = 0; r < NREG; r++) begin ready_at[r] = 0; vpend[r] = 0; end

  function automatic bit mbusy(int r);
    return (r != 0) && (vpend[r] || cyc < ready_at[r]);
  endfunction

  function automatic logic [NREG-1:0] mbusy_vec();
    logic [NREG-1:0] v;
    for (int r = 0; r < NREG; r++) v[r] = mbusy(r);
    return v;
  endfunction

  function automatic logic [1:0] efwd(logic [RA_W-1:0] r, logic en);
    if (!en) return 2'd0;
    if (m_regwrite && m_rd != 0 && m_rd == r) return 2'd1;
    if (w_regwrite && w_rd != 0 && w_rd == r) return 2'd2;
    return 2'd0;
  endfunction

  function automatic bit exp_stall();
    int src [2];
    bit use_f [2];
    bit h = 0;
    src[0] = int'(d_rs1); src[1] = int'(d_rs2);
    use_f[0] = d_use_rs1; use_f[1] = d_use_rs2;
    for (int s = 0; s < 2; s++) if (use_f[s] && src[s] != 0) begin
      if (e_memread && e_regwrite && e_rd != 0 && int'(e_rd) == src[s]) h = 1;
      if (mbusy(src[s])) h = 1;
    end
    if (d_regwrite && d_rd != 0 && mbusy(int'(d_rd))) h = 1;
    return d_valid && h && !flush;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; m_scnt = 0;
      for (int r = 0; r < NREG; r++) begin ready_at[r] = 0; vpend[r] = 0; end
    end else begin
      bit st;
      st = exp_stall();
      if (st && m_scnt < (1 << PW) - 1) m_scnt++;
      if (mc_wb_valid && vpend[mc_wb_rd]) vpend[mc_wb_rd] = 0;
      if (d_valid && !st && !flush && d_regwrite && d_rd != 0 && (d_lat != 0 || d_var_lat)) begin
        if (d_var_lat) vpend[d_rd] = 1;
        else           ready_at[d_rd] = cyc + 1 + longint'(d_lat);
      end
      cyc++;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("fwd_a", 64'(fwd_a), 64'(efwd(e_rs1, 1'b1)));
    chk("fwd_b", 64'(fwd_b), 64'(efwd(e_rs2, e_use_rs2)));
    chk("fwd_c", 64'(fwd_c), 64'(m_memwrite && w_regwrite && w_rd != 0 && w_rd == m_rs2));
    chk("stall", 64'(stall), 64'(exp_stall()));
    chk("bubble_e", 64'(bubble_e), 64'(exp_stall()));
    chk("sb_busy", 64'(sb_busy), 64'(mbusy_vec()));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_scnt));
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    {d_valid, d_use_rs1, d_use_rs2, d_regwrite, d_var_lat} = '0;
    d_rs1 = 0; d_rs2 = 0; d_rd = 0; d_lat = 0;
    e_rs1 = 0; e_rs2 = 0; e_rd = 0; m_rd = 0; m_rs2 = 0; w_rd = 0; mc_wb_rd = 0;
    {e_use_rs2, e_regwrite, e_memread, m_regwrite, m_memwrite, w_regwrite, mc_wb_valid, flush} = '0;
  endtask

  task automatic pulse_reset();
    rst_n = 0; #3; rst_n = 1;
  endtask

  task automatic issue_op(input int rd, input int lat, input bit vl);
    idle();
    d_valid = 1; d_regwrite = 1; d_rd = RA_W'(rd); d_lat = LAT_W'(lat); d_var_lat = vl;
    step();
    idle();
  endtask

  initial begin
    idle();
    rst_n = 0;
    #12; step();
    chk("reset_busy", 64'(sb_busy), 64'd0);
    chk("reset_cnt", 64'(stall_cnt), 64'd0);
    rst_n = 1;
    step();

    // Forwarding priority
    m_rd = 5; w_rd = 5; m_regwrite = 1; w_regwrite = 1; e_rs1 = 5; #1;
    chk("t1_fwd_exmem", 64'(fwd_a), 64'd1);
    m_regwrite = 0; #1;
    chk("t1_fwd_memwb", 64'(fwd_a), 64'd2);
    step(); idle();

    // Load-use
    e_memread = 1; e_regwrite = 1; e_rd = 7; d_valid = 1; d_rs1 = 7; d_use_rs1 = 1; #1;
    chk("t2_lu_stall", 64'(stall), 64'd1);
    chk("t2_lu_bubble", 64'(bubble_e), 64'd1);
    d_rs1 = 0; d_use_rs1 = 0; d_rs2 = 7; d_use_rs2 = 0; #1;
    chk("t2_unused_src", 64'(stall), 64'd0);
    step(); idle();

    // Fixed latency 4 dependent
    pulse_reset(); step();
    issue_op(3, 4, 0);
    d_valid = 1; d_rs1 = 3; d_use_rs1 = 1;
    for (int k = 0; k < 6; k++) begin
      chk("t3_stall", 64'(stall), 64'(k < 4));
      chk("t3_busy3", 64'(sb_busy[3]), 64'(k < 4));
      if (k == 4) chk("t3_stall_cnt", 64'(stall_cnt), 64'd4);
      step();
    end
    idle();

    // Variable latency WAW
    issue_op(9, 0, 1);
    for (int k = 1; k <= 11; k++) begin
      idle();
      d_valid = 1; d_regwrite = 1; d_rd = 9;
      if (k == 5)  begin mc_wb_valid = 1; mc_wb_rd = 8; end
      if (k == 10) begin mc_wb_valid = 1; mc_wb_rd = 9; end
      #1;
      chk("t4_busy9", 64'(sb_busy[9]), 64'(k <= 10));
      chk("t4_waw", 64'(stall), 64'(k <= 10));
      step();
    end
    idle();

    // x0 and flush
    issue_op(0, 3, 0);
    chk("t5_x0", 64'(sb_busy), 64'd0);
    issue_op(3, 5, 0);
    d_valid = 1; d_rs1 = 3; d_use_rs1 = 1; d_regwrite = 1; d_rd = 6; d_lat = 2; flush = 1; #1;
    chk("t5_flush_stall", 64'(stall), 64'd0);
    chk("t5_flush_bubble", 64'(bubble_e), 64'd0);
    step();
    chk("t5_no_issue", 64'(sb_busy[6]), 64'd0);
    chk("t5_busy_kept", 64'(sb_busy[3]), 64'd1);
    idle();

    // Async reset mid-countdown
    issue_op(4, 3, 0);
    step();
    rst_n = 0; #1;
    chk("t6_busy", 64'(sb_busy), 64'd0);
    chk("t6_cnt", 64'(stall_cnt), 64'd0);
    rst_n = 1;
    step();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      d_valid    = ($urandom_range(0, 9) < 8);
      d_rs1      = RA_W'($urandom_range(0, 7));
      d_rs2      = RA_W'($urandom_range(0, 7));
      d_use_rs1  = $urandom_range(0, 1);
      d_use_rs2  = $urandom_range(0, 1);
      d_rd       = RA_W'($urandom_range(0, 7));
      d_regwrite = ($urandom_range(0, 3) != 0);
      d_lat      = ($urandom_range(0, 1) == 0) ? '0 : LAT_W'($urandom_range(1, 15));
      d_var_lat  = ($urandom_range(0, 9) == 0);
      e_rs1      = RA_W'($urandom_range(0, 7));
      e_rs2      = RA_W'($urandom_range(0, 7));
      e_use_rs2  = $urandom_range(0, 1);
      e_rd       = RA_W'($urandom_range(0, 7));
      e_regwrite = $urandom_range(0, 1);
      e_memread  = ($urandom_range(0, 3) == 0);
      m_rd       = RA_W'($urandom_range(0, 7));
      m_regwrite = $urandom_range(0, 1);
      m_memwrite = $urandom_range(0, 1);
      m_rs2      = RA_W'($urandom_range(0, 7));
      w_rd       = RA_W'($urandom_range(0, 7));
      w_regwrite = $urandom_range(0, 1);
      mc_wb_valid = ($urandom_range(0, 9) < 3);
      mc_wb_rd   = RA_W'($urandom_range(0, 7));
      flush      = ($urandom_range(0, 9) == 0);
      if (n == 1500) pulse_reset();
      step();
    end
    idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
